rcs_nibble_seq: RTL and testbench

- Multi-cycle controller that runs one shared four_bit_RCS (4-bit ripple-carry adder/subtractor) nibble-serially to add or subtract 4*NIBBLES-bit operands.
- Handshake: start/busy/done.
- Drives the RCS ports directly; the RCS itself is instantiated outside this block.
- Sits between the ALU issue logic and the 4-bit RCS datapath.

---
 rtl/rcs_nibble_seq_if.sv | 27 ++
 rtl/rcs_nibble_seq.sv | 114 +++++++++++
 tb/tb_rcs_nibble_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rcs_nibble_seq_if.sv
// Issue-side bundle of the nibble-serial add/sub controller: start handshake,
// captured operands and the result/flag outputs.
interface rcs_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    modport master (
        output start, op_sub, a_in, b_in,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, op_sub, a_in, b_in,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/rcs_nibble_seq.sv
// Sequences one external 4-bit ripple-carry adder/subtractor over NIBBLES
// slices to form a 4*NIBBLES-bit sum or difference.
module rcs_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rcs_nibble_seq_if.slave      bus,
    output logic [3:0]           rcs_a,
    output logic [3:0]           rcs_b,
    output logic                 rcs_cin,
    input  logic [3:0]           rcs_s,
    input  logic                 rcs_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k;
    logic          carry;
    logic          op_sub_r;
    logic [W-1:0]  a_r, b_r, result_r;
    logic          cout_r, ovf_r;

    logic [KW+1:0] base;
    logic [3:0]    a_nib, beff;
    logic          last;

    always_comb begin
        base  = {k, 2'b00};
        a_nib = a_r[base +: 4];
        beff  = b_r[base +: 4] ^ {4{op_sub_r}};
        last  = (k == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The RCS inverts B whenever Cin is set, so B is pre-xored with carry to
    // cancel that and leave a pure a + beff + carry.
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        rcs_a     = '0;
        rcs_b     = '0;
        rcs_cin   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                rcs_a    = a_nib;
                rcs_b    = beff ^ {4{carry}};
                rcs_cin  = carry;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            carry    <= 1'b0;
            op_sub_r <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.a_in;
                        b_r      <= bus.b_in;
                        op_sub_r <= bus.op_sub;
                        carry    <= bus.op_sub;
                        k        <= '0;
                    end
                end
                RUN: begin
                    result_r[base +: 4] <= rcs_s;
                    carry               <= rcs_cout;
                    k                   <= last ? '0 : k + KW'(1);
                    if (last) begin
                        cout_r <= rcs_cout;
                        ovf_r  <= (a_nib[3] == beff[3]) && (rcs_s[3] != a_nib[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_rcs_nibble_seq.sv
// Scoreboard bench for rcs_nibble_seq with a behavioural 4-bit RCS attached.
module tb_rcs_nibble_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rcs_a, rcs_b, rcs_s;
    logic       rcs_cin, rcs_cout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    rcs_nibble_seq_if #(.NIBBLES(NIB)) bus ();

    rcs_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rcs_a    (rcs_a),
        .rcs_b    (rcs_b),
        .rcs_cin  (rcs_cin),
        .rcs_s    (rcs_s),
        .rcs_cout (rcs_cout)
    );

    // Reference four_bit_RCS: {Cout,S} = A + (B ^ {4{Cin}}) + Cin
    always_comb begin
        {rcs_cout, rcs_s} = {1'b0, rcs_a} + {1'b0, rcs_b ^ {4{rcs_cin}}} + {4'b0, rcs_cin};
    end

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", n, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_result"}, 32'(bus.result), 32'(e.r));
                chk({e.name, "_cout"}, 32'(bus.cout), 32'(e.c));
                chk({e.name, "_ovf"}, 32'(bus.overflow), 32'(e.v));
                chk({e.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ev,
                          input string name, input bit chk_first, input bit poke);
        exp_t        e;
        int unsigned lat;
        int unsigned busy_n;
        bit          seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = sub;
        bus.a_in   = a;
        bus.b_in   = b;
        e.r = er; e.c = ec; e.v = ev; e.name = name;
        exp_q.push_back(e);
        lat = 0; busy_n = 0; seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a_in  = ~a;
            bus.b_in  = a ^ b;
            if (bus.busy === 1'b1) busy_n++;
            if (chk_first && c == 1) begin
                chk({name, "_first_rcs_a"}, 32'(rcs_a), 32'd5);
                chk({name, "_first_rcs_b"}, 32'(rcs_b), 32'd3);
                chk({name, "_first_rcs_cin"}, 32'(rcs_cin), 32'd1);
            end
            if (poke && c == 2) begin
                bus.start  = 1'b1;
                bus.op_sub = ~sub;
                bus.a_in   = 16'hAAAA;
                bus.b_in   = 16'h5555;
            end
            if (bus.done === 1'b1) begin
                seen = 1;
                lat  = c;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(NIB + 1));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(NIB));
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_rcs_a", 32'(rcs_a), 32'd0);
        chk("rst_rcs_b", 32'(rcs_b), 32'd0);
        chk("rst_rcs_cin", 32'(rcs_cin), 32'd0);
        rst = 1'b0;

        run_op(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, "add_1234_0fff", 0, 0);
        run_op(1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, "sub_5_3", 1, 0);
        run_op(1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, "sub_3_5", 0, 0);
        run_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "add_ffff_1", 0, 0);
        run_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "add_7fff_1", 0, 0);
        run_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1", 0, 0);
        run_op(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, "add_poke", 0, 1);
        // issued in the IDLE cycle right after the previous done
        run_op(1'b0, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0, "add_back2back", 0, 0);

        // abort in the second RUN cycle
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = 1'b0;
        bus.a_in   = 16'h1234;
        bus.b_in   = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        chk("abort_ovf", 32'(bus.overflow), 32'd0);
        chk("abort_rcs_a", 32'(rcs_a), 32'd0);
        chk("abort_rcs_b", 32'(rcs_b), 32'd0);
        chk("abort_rcs_cin", 32'(rcs_cin), 32'd0);
        repeat (8) @(negedge clk);

        run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "add_after_abort", 0, 0);

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
